uart_tx_byte_serializer: RTL and testbench

Byte-level UART transmitter that sits directly downstream of the packet FIFO's send side and consumes its byte stream. It accepts one byte per write strobe into a small internal byte FIFO. It signals availability back upstream so the packet FIFO paces its strobes. It serialises each byte as an asynchronous frame: start, 8 data bits LSB-first, optional even parity, then 1 or 2 stop bits.

---
 rtl/uart_tx_byte_serializer.sv | 218 +++++++++++++++++++++
 tb/tb_uart_tx_byte_serializer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_byte_serializer.sv
// uart_tx_byte_serializer: byte FIFO feeding an async UART frame serializer.
// Frame: start, 8 data bits LSB-first, optional even parity, 1 or 2 stops.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   wr_data      byte to queue, valid with wr_stb
//   wr_stb       write attempt on each sampling edge
//   wr_ready     FIFO not full (upstream pacing)
//   tx           serial line, idles high
//   tx_busy      a frame is on the line
//   fifo_empty   FIFO holds no bytes
//   fifo_full    FIFO holds FIFO_DEPTH bytes
//   overflow     sticky: a write hit a full FIFO
//   clr_overflow synchronous clear of overflow

module uart_tx_byte_serializer #(
   parameter int CLK_PER_BIT = 13021,
   parameter int FIFO_DEPTH  = 4,
   parameter int PARITY_EN   = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] wr_data,
   input  logic       wr_stb,
   output logic       wr_ready,
   output logic       tx,
   output logic       tx_busy,
   output logic       fifo_empty,
   output logic       fifo_full,
   output logic       overflow,
   input  logic       clr_overflow
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int BW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
   localparam logic          STOP_LAST = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t         state;
   logic [7:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic [BW-1:0]  baud_cnt;
   logic [2:0]     bit_cnt;
   logic           stop_cnt;
   logic [7:0]     shift;
   logic           par;

   logic           push;
   logic           pop;
   logic           baud_wrap;
   logic           last_stop;
   logic [7:0]     head;

   assign fifo_full  = (count == CNT_FULL);
   assign fifo_empty = (count == '0);
   assign wr_ready   = !fifo_full;

   assign push      = wr_stb && !fifo_full;
   assign baud_wrap = (baud_cnt == BAUD_LAST);
   assign last_stop = (stop_cnt == STOP_LAST);
   assign head      = mem[rd_ptr];

   // The FSM takes the head byte either from IDLE or at the very edge
   // that closes the last stop bit, so back-to-back frames have no gap.
   assign pop = !fifo_empty &&
                ((state == IDLE) ||
                 ((state == STOP) && baud_wrap && last_stop));

   // Byte storage: no reset needed, validity is tracked by count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         // A dropped write beats a same-cycle clear.
         if (wr_stb && fifo_full) begin
            overflow <= 1'b1;
         end else if (clr_overflow) begin
            overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         shift    <= '0;
         par      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               tx <= 1'b1;
               if (pop) begin
                  shift    <= head;
                  par      <= 1'b0;
                  tx       <= 1'b0;
                  tx_busy  <= 1'b1;
                  baud_cnt <= '0;
                  state    <= START;
               end
            end

            START: begin
               if (baud_wrap) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  tx       <= shift[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end

            DATA: begin
               if (baud_wrap) begin
                  baud_cnt <= '0;
                  shift    <= {1'b0, shift[7:1]};
                  par      <= par ^ shift[0];
                  if (bit_cnt == 3'd7) begin
                     if (PARITY_EN != 0) begin
                        tx    <= par ^ shift[0];
                        state <= PARITY;
                     end else begin
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     tx      <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end

            PARITY: begin
               if (baud_wrap) begin
                  baud_cnt <= '0;
                  tx       <= 1'b1;
                  stop_cnt <= 1'b0;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end

            STOP: begin
               if (baud_wrap) begin
                  baud_cnt <= '0;
                  if (last_stop) begin
                     if (pop) begin
                        shift <= head;
                        par   <= 1'b0;
                        tx    <= 1'b0;
                        state <= START;
                     end else begin
                        tx      <= 1'b1;
                        tx_busy <= 1'b0;
                        state   <= IDLE;
                     end
                  end else begin
                     stop_cnt <= 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end

            default: begin
               tx      <= 1'b1;
               tx_busy <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_byte_serializer.sv
// tb_uart_tx_byte_serializer: two serializer configs driven in lockstep
// against a queue-based model of the FIFO and the expected line waveform.

module tb_uart_tx_byte_serializer;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   typedef logic       bitq_t[$];
   typedef logic [7:0] byteq_t[$];

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] wr_data;
   logic       wr_stb;
   logic       clr_overflow;

   logic a_ready, a_tx, a_busy, a_empty, a_full, a_ovf;
   logic b_ready, b_tx, b_busy, b_empty, b_full, b_ovf;

   always #5 clk = ~clk;

   uart_tx_byte_serializer #(
      .CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH),
      .PARITY_EN(0), .STOP_BITS(1)
   ) dut_a (
      .clk(clk), .rst_n(rst_n),
      .wr_data(wr_data), .wr_stb(wr_stb),
      .wr_ready(a_ready), .tx(a_tx), .tx_busy(a_busy),
      .fifo_empty(a_empty), .fifo_full(a_full),
      .overflow(a_ovf), .clr_overflow(clr_overflow)
   );

   uart_tx_byte_serializer #(
      .CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH),
      .PARITY_EN(1), .STOP_BITS(2)
   ) dut_b (
      .clk(clk), .rst_n(rst_n),
      .wr_data(wr_data), .wr_stb(wr_stb),
      .wr_ready(b_ready), .tx(b_tx), .tx_busy(b_busy),
      .fifo_empty(b_empty), .fifo_full(b_full),
      .overflow(b_ovf), .clr_overflow(clr_overflow)
   );

   // Model: accepted bytes, and the per-cycle tx values still to appear.
   byteq_t fq_a, fq_b;
   bitq_t  lq_a, lq_b;
   logic   ov_a, ov_b;

   int n_assert = 0;
   int n_fail   = 0;

   function automatic bitq_t expand(input logic [7:0] d,
                                    input int par, input int stop);
      bitq_t bits;
      bitq_t q;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (par != 0) bits.push_back(^d);
      for (int s = 0; s < stop; s++) bits.push_back(1'b1);
      for (int k = 0; k < bits.size(); k++)
         for (int c = 0; c < CPB; c++) q.push_back(bits[k]);
      return q;
   endfunction

   function automatic void mstep(inout byteq_t fq, inout bitq_t lq,
                                 inout logic ov, input int par,
                                 input int stop, input logic stb,
                                 input logic clr, input logic [7:0] d);
      logic full_b;
      full_b = (fq.size() == DEPTH);
      if (lq.size() != 0) lq.delete(0);
      if (lq.size() == 0 && fq.size() != 0)
         lq = expand(fq.pop_front(), par, stop);
      if (stb && !full_b) fq.push_back(d);
      if (stb && full_b) ov = 1'b1;
      else if (clr) ov = 1'b0;
   endfunction

   task automatic mreset();
      fq_a.delete(); fq_b.delete();
      lq_a.delete(); lq_b.delete();
      ov_a = 1'b0; ov_b = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("a_tx", a_tx, (lq_a.size() != 0) ? lq_a[0] : 1'b1);
      chk("a_busy", a_busy, lq_a.size() != 0);
      chk("a_empty", a_empty, fq_a.size() == 0);
      chk("a_full", a_full, fq_a.size() == DEPTH);
      chk("a_ready", a_ready, fq_a.size() != DEPTH);
      chk("a_ovf", a_ovf, ov_a);
      chk("b_tx", b_tx, (lq_b.size() != 0) ? lq_b[0] : 1'b1);
      chk("b_busy", b_busy, lq_b.size() != 0);
      chk("b_empty", b_empty, fq_b.size() == 0);
      chk("b_full", b_full, fq_b.size() == DEPTH);
      chk("b_ready", b_ready, fq_b.size() != DEPTH);
      chk("b_ovf", b_ovf, ov_b);
   endtask

   task automatic step(input logic stb, input logic [7:0] d,
                       input logic clr);
      wr_stb       = stb;
      wr_data      = d;
      clr_overflow = clr;
      @(posedge clk);
      mstep(fq_a, lq_a, ov_a, 0, 1, stb, clr, d);
      mstep(fq_b, lq_b, ov_b, 1, 2, stb, clr, d);
      #1;
      wr_stb       = 1'b0;
      clr_overflow = 1'b0;
      check_all();
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      rst_n        = 1'b0;
      wr_stb       = 1'b0;
      wr_data      = 8'h00;
      clr_overflow = 1'b0;
      mreset();
      repeat (3) @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
      idle(2);

      // single byte
      step(1'b1, 8'hA5, 1'b0);
      idle(60);

      // burst of six: one popped, four fill, sixth dropped
      for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0);
      idle(300);

      // clear without write, then clear colliding with a dropped write
      step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
      step(1'b1, 8'($urandom), 1'b1);
      idle(300);
      step(1'b0, 8'h00, 1'b1);

      // parity / two stop bits reference byte
      step(1'b1, 8'h07, 1'b0);
      idle(60);

      // random traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) == 0, 8'($urandom),
              $urandom_range(0, 19) == 0);
      idle(300);

      // reset in the middle of a data bit with three bytes queued
      for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0);
      idle(15);
      #4;
      rst_n = 1'b0;
      mreset();
      #1;
      check_all();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
      idle(100);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
